// File: rtl/filter_frame_controller.sv
// Frame sequencer for the RGB filter pipeline: admits one frame of pixel beats, generates m_tlast,
// then watches output columns drain and reports done, protocol errors and a frame count.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | waiting for start; upstream stalled
// S_FEED  | passing beats to input_buffer, m_tlast on the final beat
// S_DRAIN | upstream stalled, waiting for output columns or watchdog
// S_DONE  | one-cycle completion: done pulse, frame_count increments
module filter_frame_controller #(
    parameter int C_AXIS_TDATA_WIDTH = 32,
    parameter int INPUT_HEIGHT       = 10,
    parameter int COUNT_WIDTH        = 16,
    parameter int TIMEOUT_WIDTH      = 8
) (
    input  logic                          aclk,
    input  logic                          areset,
    input  logic                          start,
    input  logic [COUNT_WIDTH-1:0]        cfg_columns,
    input  logic [COUNT_WIDTH-1:0]        cfg_out_columns,
    input  logic [C_AXIS_TDATA_WIDTH-1:0] s_tdata,
    input  logic                          s_tvalid,
    output logic                          s_tready,
    input  logic                          s_tlast,
    output logic [C_AXIS_TDATA_WIDTH-1:0] m_tdata,
    output logic                          m_tvalid,
    input  logic                          m_tready,
    output logic                          m_tlast,
    input  logic                          out_tvalid,
    input  logic                          out_tready,
    input  logic                          out_tlast,
    output logic                          busy,
    output logic                          done,
    output logic                          err_tlast_early,
    output logic                          err_tlast_missing,
    output logic                          err_timeout,
    output logic [COUNT_WIDTH-1:0]        frame_count
);

    localparam int TOTW = COUNT_WIDTH + $clog2(INPUT_HEIGHT + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FEED  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                   state_q, state_d;
    logic [TOTW-1:0]          total_q, total_d;
    logic [TOTW-1:0]          beat_cnt_q, beat_cnt_d;
    logic [COUNT_WIDTH-1:0]   out_cols_q, out_cols_d;
    logic [COUNT_WIDTH-1:0]   out_col_cnt_q, out_col_cnt_d;
    logic [COUNT_WIDTH-1:0]   frame_count_q, frame_count_d;
    logic [TIMEOUT_WIDTH-1:0] wdog_q, wdog_d;
    logic                     err_early_q, err_early_d;
    logic                     err_missing_q, err_missing_d;
    logic                     err_timeout_q, err_timeout_d;

    logic                   start_acc;
    logic                   beat_hs;
    logic                   final_beat;
    logic                   out_hs;
    logic                   out_col_hs;
    logic                   cols_done;
    logic                   wdog_full;
    logic [COUNT_WIDTH-1:0] cfg_cols_eff;
    logic [COUNT_WIDTH-1:0] cfg_out_eff;

    assign start_acc    = (state_q == S_IDLE) && start;
    assign beat_hs      = (state_q == S_FEED) && s_tvalid && m_tready;
    assign final_beat   = (beat_cnt_q == (total_q - TOTW'(1)));
    assign out_hs       = out_tvalid && out_tready;
    assign out_col_hs   = out_hs && out_tlast;
    assign cols_done    = (out_col_cnt_q >= out_cols_q);
    assign wdog_full    = &wdog_q;
    assign cfg_cols_eff = (cfg_columns == '0) ? COUNT_WIDTH'(1) : cfg_columns;
    assign cfg_out_eff  = (cfg_out_columns == '0) ? COUNT_WIDTH'(1) : cfg_out_columns;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_FEED;
            S_FEED:  if (beat_hs && final_beat) state_d = S_DRAIN;
            // column completion takes priority over a simultaneous watchdog expiry
            S_DRAIN: if (cols_done || wdog_full) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        s_tready = (state_q == S_FEED) && m_tready;
        m_tvalid = (state_q == S_FEED) && s_tvalid;
        m_tlast  = (state_q == S_FEED) && final_beat;
        busy     = (state_q == S_FEED) || (state_q == S_DRAIN);
        done     = (state_q == S_DONE);
    end

    always_comb begin
        total_d       = total_q;
        beat_cnt_d    = beat_cnt_q;
        out_cols_d    = out_cols_q;
        out_col_cnt_d = out_col_cnt_q;
        frame_count_d = frame_count_q;
        wdog_d        = wdog_q;
        err_early_d   = err_early_q;
        err_missing_d = err_missing_q;
        err_timeout_d = err_timeout_q;

        if (start_acc) begin
            total_d       = TOTW'(cfg_cols_eff) * TOTW'(INPUT_HEIGHT);
            out_cols_d    = cfg_out_eff;
            beat_cnt_d    = '0;
            out_col_cnt_d = '0;
            wdog_d        = '0;
            err_early_d   = 1'b0;
            err_missing_d = 1'b0;
            err_timeout_d = 1'b0;
        end

        if (beat_hs) begin
            beat_cnt_d = beat_cnt_q + TOTW'(1);
            if (s_tlast && !final_beat) err_early_d = 1'b1;
            if (!s_tlast && final_beat) err_missing_d = 1'b1;
        end

        if (((state_q == S_FEED) || (state_q == S_DRAIN)) && out_col_hs && (out_col_cnt_q != '1)) begin
            out_col_cnt_d = out_col_cnt_q + COUNT_WIDTH'(1);
        end

        if (state_q == S_DRAIN) begin
            wdog_d = out_hs ? '0 : wdog_q + TIMEOUT_WIDTH'(1);
            if (wdog_full && !cols_done) err_timeout_d = 1'b1;
        end

        if (state_q == S_DONE) begin
            frame_count_d = frame_count_q + COUNT_WIDTH'(1);
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            total_q       <= '0;
            beat_cnt_q    <= '0;
            out_cols_q    <= '0;
            out_col_cnt_q <= '0;
            frame_count_q <= '0;
            wdog_q        <= '0;
            err_early_q   <= 1'b0;
            err_missing_q <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            total_q       <= total_d;
            beat_cnt_q    <= beat_cnt_d;
            out_cols_q    <= out_cols_d;
            out_col_cnt_q <= out_col_cnt_d;
            frame_count_q <= frame_count_d;
            wdog_q        <= wdog_d;
            err_early_q   <= err_early_d;
            err_missing_q <= err_missing_d;
            err_timeout_q <= err_timeout_d;
        end
    end

    assign m_tdata           = s_tdata;
    assign err_tlast_early   = err_early_q;
    assign err_tlast_missing = err_missing_q;
    assign err_timeout       = err_timeout_q;
    assign frame_count       = frame_count_q;

endmodule

// File: tb/tb_filter_frame_controller.sv
// Randomized self-checking bench for filter_frame_controller; expectations come from a frame-level
// model (beat count, column count, error predictions) kept in the bench.
module tb_filter_frame_controller;

    localparam int DW = 32;
    localparam int H  = 10;
    localparam int CW = 16;

    logic          aclk = 1'b0;
    logic          areset;
    logic          start;
    logic [CW-1:0] cfg_columns, cfg_out_columns;
    logic [DW-1:0] s_tdata;
    logic          s_tvalid, s_tready, s_tlast;
    logic [DW-1:0] m_tdata;
    logic          m_tvalid, m_tready, m_tlast;
    logic          out_tvalid, out_tready, out_tlast;
    logic          busy, done, err_tlast_early, err_tlast_missing, err_timeout;
    logic [CW-1:0] frame_count;

    int checks = 0;
    int failures = 0;
    int exp_frames = 0;

    always #5 aclk = ~aclk;

    filter_frame_controller #(
        .C_AXIS_TDATA_WIDTH(DW), .INPUT_HEIGHT(H), .COUNT_WIDTH(CW), .TIMEOUT_WIDTH(8)
    ) dut (
        .aclk(aclk), .areset(areset), .start(start),
        .cfg_columns(cfg_columns), .cfg_out_columns(cfg_out_columns),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tlast(s_tlast),
        .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast),
        .out_tvalid(out_tvalid), .out_tready(out_tready), .out_tlast(out_tlast),
        .busy(busy), .done(done), .err_tlast_early(err_tlast_early),
        .err_tlast_missing(err_tlast_missing), .err_timeout(err_timeout), .frame_count(frame_count)
    );

    initial begin
        #5000000;
        $display("FAIL global_timeout simulation did not finish in time");
        $fatal(1, "global timeout");
    end

    task automatic idle_inputs();
        start = 1'b0; s_tvalid = 1'b0; s_tlast = 1'b0; m_tready = 1'b0;
        out_tvalid = 1'b0; out_tready = 1'b0; out_tlast = 1'b0;
    endtask

    // One frame from start to done. abort_beat >= 0 applies reset when that beat is pending.
    task automatic run_frame(input int cols, input int out_cols, input int early_beat, input bit missing,
                             input bit rand_hs, input int out_send, input bit start_noise, input int abort_beat);
        int  eff_cols, eff_out, total, beat, sent, budget, idle;
        bit  exp_early, exp_timeout, exp_last, got_done;
        eff_cols    = (cols == 0) ? 1 : cols;
        eff_out     = (out_cols == 0) ? 1 : out_cols;
        total       = eff_cols * H;
        exp_early   = (early_beat >= 0) && (early_beat < total - 1);
        exp_timeout = (out_send < eff_out);
        beat = 0; sent = 0;

        @(negedge aclk);
        start = 1'b1; cfg_columns = CW'(cols); cfg_out_columns = CW'(out_cols);
        #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL idle_busy got=%b exp=0", busy); end
        @(negedge aclk);
        start = 1'b0; cfg_columns = CW'($urandom_range(1, 50)); cfg_out_columns = CW'($urandom_range(1, 50));
        #1;
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL feed_busy got=%b exp=1", busy); end
        checks++; if ({err_tlast_early, err_tlast_missing, err_timeout} !== 3'b000) begin
            failures++; $display("FAIL err_cleared_on_start got=%b exp=000", {err_tlast_early, err_tlast_missing, err_timeout});
        end

        budget = total * 20 + 100;
        while (beat < total && budget > 0) begin
            if (abort_beat >= 0 && beat == abort_beat) begin
                areset = 1'b1; s_tvalid = 1'b1; m_tready = 1'b1;
                #1;
                checks++; if ({busy, done, s_tready, m_tvalid, m_tlast} !== 5'b0) begin
                    failures++; $display("FAIL reset_outputs got=%b exp=00000", {busy, done, s_tready, m_tvalid, m_tlast});
                end
                checks++; if (frame_count !== '0) begin failures++; $display("FAIL reset_frame_count got=%0d exp=0", frame_count); end
                @(negedge aclk);
                areset = 1'b0; idle_inputs(); exp_frames = 0;
                #1;
                checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_idle_busy got=%b exp=0", busy); end
                return;
            end
            s_tvalid = rand_hs ? 1'($urandom_range(0, 1)) : 1'b1;
            m_tready = rand_hs ? 1'($urandom_range(0, 1)) : 1'b1;
            s_tdata  = $urandom;
            s_tlast  = (beat == early_beat) || ((beat == total - 1) && !missing);
            start    = start_noise ? 1'($urandom_range(0, 1)) : 1'b0;
            if (rand_hs) begin
                out_tvalid = 1'($urandom_range(0, 1));
                out_tready = 1'($urandom_range(0, 1));
                out_tlast  = ($urandom_range(0, 2) == 0) && (sent < out_send);
            end
            exp_last = (beat == total - 1);
            #1;
            checks++; if (m_tvalid !== s_tvalid) begin failures++; $display("FAIL feed_m_tvalid beat=%0d got=%b exp=%b", beat, m_tvalid, s_tvalid); end
            checks++; if (s_tready !== m_tready) begin failures++; $display("FAIL feed_s_tready beat=%0d got=%b exp=%b", beat, s_tready, m_tready); end
            checks++; if (m_tdata !== s_tdata) begin failures++; $display("FAIL feed_m_tdata beat=%0d got=%h exp=%h", beat, m_tdata, s_tdata); end
            checks++; if (m_tlast !== exp_last) begin failures++; $display("FAIL feed_m_tlast beat=%0d got=%b exp=%b", beat, m_tlast, exp_last); end
            checks++; if (done !== 1'b0) begin failures++; $display("FAIL feed_done beat=%0d got=%b exp=0", beat, done); end
            if (s_tvalid && m_tready) beat++;
            if (out_tvalid && out_tready && out_tlast) sent++;
            @(negedge aclk);
            budget--;
        end
        checks++; if (beat != total) begin failures++; $display("FAIL feed_budget beats got=%0d exp=%0d", beat, total); end

        idle_inputs();
        s_tvalid = 1'b1; m_tready = 1'b1;
        #1;
        checks++; if ({m_tvalid, s_tready, m_tlast, busy} !== 4'b0001) begin
            failures++; $display("FAIL drain_gating got=%b exp=0001", {m_tvalid, s_tready, m_tlast, busy});
        end
        s_tvalid = 1'b0; m_tready = 1'b0;

        while (sent < out_send) begin
            start = start_noise ? 1'($urandom_range(0, 1)) : 1'b0;
            out_tvalid = 1'b1; out_tready = 1'b1; out_tlast = 1'b1;
            #1;
            checks++; if (done !== 1'b0) begin failures++; $display("FAIL drain_early_done sent=%0d got=%b exp=0", sent, done); end
            sent++;
            @(negedge aclk);
            out_tlast = 1'b0;
            if (sent < out_send) begin
                for (int g = $urandom_range(0, 3); g > 0; g--) begin
                    out_tvalid = 1'($urandom_range(0, 1)); out_tready = 1'($urandom_range(0, 1));
                    start = start_noise ? 1'($urandom_range(0, 1)) : 1'b0;
                    @(negedge aclk);
                end
            end
        end
        idle_inputs();

        idle = 0; got_done = 1'b0; budget = 600;
        while (budget > 0) begin
            #1;
            if (done) begin got_done = 1'b1; break; end
            idle++; budget--;
            @(negedge aclk);
        end
        checks++; if (!got_done) begin failures++; $display("FAIL done_wait got=no_done exp=done_pulse"); end
        if (exp_timeout) begin
            checks++; if (idle < 255 || idle > 257) begin failures++; $display("FAIL timeout_latency got=%0d exp=255..257", idle); end
        end
        checks++; if (err_timeout !== exp_timeout) begin failures++; $display("FAIL err_timeout got=%b exp=%b", err_timeout, exp_timeout); end
        checks++; if (err_tlast_early !== exp_early) begin failures++; $display("FAIL err_tlast_early got=%b exp=%b", err_tlast_early, exp_early); end
        checks++; if (err_tlast_missing !== missing) begin failures++; $display("FAIL err_tlast_missing got=%b exp=%b", err_tlast_missing, missing); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL done_busy got=%b exp=0", busy); end
        checks++; if (frame_count !== CW'(exp_frames)) begin failures++; $display("FAIL pre_frame_count got=%0d exp=%0d", frame_count, exp_frames); end
        @(negedge aclk);
        exp_frames++;
        #1;
        checks++; if (frame_count !== CW'(exp_frames)) begin failures++; $display("FAIL frame_count got=%0d exp=%0d", frame_count, exp_frames); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL done_one_cycle got=%b exp=0", done); end
        checks++; if ({err_tlast_early, err_tlast_missing, err_timeout} !== {exp_early, missing, exp_timeout}) begin
            failures++; $display("FAIL err_sticky got=%b exp=%b", {err_tlast_early, err_tlast_missing, err_timeout}, {exp_early, missing, exp_timeout});
        end
    endtask

    task automatic test_reset();
        areset = 1'b1; idle_inputs(); s_tvalid = 1'b1; m_tready = 1'b1; s_tdata = 32'hA5A5_1234;
        cfg_columns = '0; cfg_out_columns = '0;
        repeat (3) @(negedge aclk);
        #1;
        checks++; if ({busy, done, s_tready, m_tvalid, m_tlast} !== 5'b0) begin
            failures++; $display("FAIL reset_ctrl got=%b exp=00000", {busy, done, s_tready, m_tvalid, m_tlast});
        end
        checks++; if ({err_tlast_early, err_tlast_missing, err_timeout} !== 3'b0) begin
            failures++; $display("FAIL reset_err got=%b exp=000", {err_tlast_early, err_tlast_missing, err_timeout});
        end
        checks++; if (frame_count !== '0) begin failures++; $display("FAIL reset_count got=%0d exp=0", frame_count); end
        checks++; if (m_tdata !== s_tdata) begin failures++; $display("FAIL reset_tdata got=%h exp=%h", m_tdata, s_tdata); end
        @(negedge aclk);
        areset = 1'b0; idle_inputs();
        exp_frames = 0;
    endtask

    task automatic test_basic();
        run_frame(10, 8, -1, 1'b0, 1'b0, 8, 1'b0, -1);
    endtask

    task automatic test_random_handshake();
        run_frame(10, 8, -1, 1'b0, 1'b1, 8, 1'b0, -1);
        for (int i = 0; i < 3; i++) begin
            int c, o;
            c = $urandom_range(1, 6);
            o = $urandom_range(1, 5);
            run_frame(c, o, -1, 1'b0, 1'b1, o, 1'b0, -1);
        end
    endtask

    task automatic test_tlast_errors();
        run_frame(10, 8, 49, 1'b1, 1'b0, 8, 1'b0, -1);
    endtask

    task automatic test_timeout();
        run_frame(10, 8, -1, 1'b0, 1'b0, 5, 1'b0, -1);
    endtask

    task automatic test_reset_midframe();
        run_frame(10, 8, -1, 1'b0, 1'b0, 8, 1'b0, 40);
        run_frame(10, 8, -1, 1'b0, 1'b0, 8, 1'b0, -1);
        checks++; if (frame_count !== CW'(1)) begin failures++; $display("FAIL after_reset_count got=%0d exp=1", frame_count); end
    endtask

    task automatic test_back_to_back();
        run_frame(4, 3, 10, 1'b0, 1'b1, 3, 1'b1, -1);
        run_frame(4, 3, -1, 1'b0, 1'b1, 3, 1'b1, -1);
    endtask

    task automatic test_zero_cfg();
        run_frame(0, 0, -1, 1'b0, 1'b1, 1, 1'b0, -1);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_random_handshake();
        test_tlast_errors();
        test_timeout();
        test_reset_midframe();
        test_back_to_back();
        test_zero_cfg();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
